lcd_text_sequencer: RTL and testbench

LCD_TEXT_SEQUENCER -- requirements
Module: lcd_text_sequencer

---
 rtl/lcd_text_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_lcd_text_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer: power-up wait, HD44780-style init, and redraw of a
// 32-byte text buffer through a start/done LCD controller.
// Build option: define LCD_LINE2_EN to also draw line 2 (buffer[16..31]).
//
// state    | meaning
// ---------+---------------------------------------------------------
// PWRUP    | power-up wait, counter runs to PWRUP_CYCLES-1
// LOAD     | register data/RS for the current step, start low
// START    | data stable for one cycle, raise start on the next edge
// WAITDONE | hold start and data until the controller reports done
// GAP      | wait GAP_CYCLES before the next step
// IDLE     | not busy, waiting for a refresh request
module lcd_text_sequencer #(
    parameter int PWRUP_CYCLES = 1000000,
    parameter int GAP_CYCLES   = 131071
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iWR,
    input  logic [4:0] iWADDR,
    input  logic [7:0] iWDATA,
    input  logic       iREFRESH,
    output logic       oBusy,
    output logic       oInitDone,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_Start,
    input  logic       iLCD_Done
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_LOAD,
        S_START,
        S_WAITDONE,
        S_GAP,
        S_IDLE
    } state_t;

`ifdef LCD_LINE2_EN
    localparam logic [5:0] LAST_STEP = 6'd37;
`else
    localparam logic [5:0] LAST_STEP = 6'd20;
`endif

    localparam logic [19:0] PWRUP_TC = 20'(PWRUP_CYCLES - 1);
    localparam logic [19:0] GAP_TC   = 20'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [5:0]  step_q, step_d;
    logic        pending_q, pending_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        start_q, start_d;
    logic        init_done_q, init_done_d;
    logic        first_q, first_d;
    logic [7:0]  buf_q [32];
    logic [7:0]  buf_d [32];

    logic [7:0]  load_byte;
    logic        load_rs;
    logic [4:0]  line1_idx;
`ifdef LCD_LINE2_EN
    logic [4:0]  line2_idx;
`endif

    // Text buffer: host writes land on any cycle, in every state.
    always_comb begin
        buf_d = buf_q;
        if (iWR) begin
            buf_d[iWADDR] = iWDATA;
        end
    end

    // Text buffer storage, cleared to spaces on reset.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 32; i++) begin
                buf_q[i] <= 8'h20;
            end
        end else begin
            buf_q <= buf_d;
        end
    end

    // Step table: byte and RS for the current step (buffer read is pre-write).
    always_comb begin
        load_byte = 8'h20;
        load_rs   = 1'b0;
        line1_idx = 5'(step_q - 6'd5);
`ifdef LCD_LINE2_EN
        line2_idx = 5'(step_q - 6'd6);
`endif
        case (step_q)
            6'd0: load_byte = 8'h38;
            6'd1: load_byte = 8'h0C;
            6'd2: load_byte = 8'h01;
            6'd3: load_byte = 8'h06;
            6'd4: load_byte = 8'h80;
`ifdef LCD_LINE2_EN
            6'd21: load_byte = 8'hC0;
`endif
            default: begin
                if (step_q >= 6'd5 && step_q <= 6'd20) begin
                    load_byte = buf_q[line1_idx];
                    load_rs   = 1'b1;
                end
`ifdef LCD_LINE2_EN
                else if (step_q >= 6'd22) begin
                    load_byte = buf_q[line2_idx];
                    load_rs   = 1'b1;
                end
`endif
            end
        endcase
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        pending_d   = pending_q | iREFRESH;
        data_d      = data_q;
        rs_d        = rs_q;
        start_d     = start_q;
        init_done_d = init_done_q;
        first_d     = first_q;

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWRUP_TC) begin
                    cnt_d   = 20'd0;
                    step_d  = 6'd0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            S_LOAD: begin
                data_d  = load_byte;
                rs_d    = load_rs;
                start_d = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                start_d = 1'b1;
                first_d = 1'b1;
                state_d = S_WAITDONE;
            end
            S_WAITDONE: begin
                start_d = 1'b1;
                first_d = 1'b0;
                // Done seen in the first cycle is left over from the previous
                // command; the controller has not reacted to our edge yet.
                if (!first_q && iLCD_Done) begin
                    start_d = 1'b0;
                    cnt_d   = 20'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_TC) begin
                    cnt_d = 20'd0;
                    if (step_q == 6'd3) begin
                        init_done_d = 1'b1;
                    end
                    if (step_q == LAST_STEP) begin
                        state_d = S_IDLE;
                    end else begin
                        step_d  = step_q + 6'd1;
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            S_IDLE: begin
                if (iREFRESH || pending_q) begin
                    step_d    = 6'd4;
                    pending_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            default: begin
                state_d = S_PWRUP;
                cnt_d   = 20'd0;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= S_PWRUP;
            cnt_q       <= 20'd0;
            step_q      <= 6'd0;
            pending_q   <= 1'b0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            start_q     <= 1'b0;
            init_done_q <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            pending_q   <= pending_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            start_q     <= start_d;
            init_done_q <= init_done_d;
            first_q     <= first_d;
        end
    end

    assign oBusy      = (state_q != S_IDLE);
    assign oInitDone  = init_done_q;
    assign oLCD_DATA  = data_q;
    assign oLCD_RS    = rs_q;
    assign oLCD_Start = start_q;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Scoreboard bench for lcd_text_sequencer with a start/done controller model.
module tb_lcd_text_sequencer;

    localparam int PWR = 10;
    localparam int GAP = 4;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iWR = 1'b0;
    logic [4:0] iWADDR = 5'd0;
    logic [7:0] iWDATA = 8'h00;
    logic       iREFRESH = 1'b0;
    logic       iLCD_Done = 1'b0;
    logic       oBusy, oInitDone, oLCD_RS, oLCD_Start;
    logic [7:0] oLCD_DATA;

    lcd_text_sequencer #(.PWRUP_CYCLES(PWR), .GAP_CYCLES(GAP)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iWR(iWR), .iWADDR(iWADDR),
        .iWDATA(iWDATA), .iREFRESH(iREFRESH), .oBusy(oBusy),
        .oInitDone(oInitDone), .oLCD_DATA(oLCD_DATA), .oLCD_RS(oLCD_RS),
        .oLCD_Start(oLCD_Start), .iLCD_Done(iLCD_Done)
    );

    always #5 iCLK = ~iCLK;

    int n_vec = 0;
    int n_err = 0;
    int n_starts = 0;
    int n_falls = 0;
    logic [8:0] sb [$];
    logic [7:0] exp_buf [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Controller model: done drops one cycle late (stale) and rises 20 cycles after start.
    int   mdl_cnt = 0;
    logic mdl_clr = 1'b0;
    logic mdl_prev = 1'b0;
    logic real_done = 1'b0;
    always @(negedge iCLK) begin
        if (!iRST_N) begin
            iLCD_Done = 1'b0;
            mdl_cnt   = 0;
            mdl_clr   = 1'b0;
            mdl_prev  = 1'b0;
            real_done = 1'b0;
        end else begin
            if (oLCD_Start && !mdl_prev) begin
                mdl_clr   = 1'b1;
                mdl_cnt   = 20;
                real_done = 1'b0;
            end else begin
                if (mdl_clr) begin
                    iLCD_Done = 1'b0;
                    mdl_clr   = 1'b0;
                end
                if (mdl_cnt > 0) begin
                    mdl_cnt--;
                    if (mdl_cnt == 0) begin
                        iLCD_Done = 1'b1;
                        real_done = 1'b1;
                    end
                end
            end
            mdl_prev = oLCD_Start;
        end
    end

    // Monitor: every start edge pops one expected {rs,data}; every release needs a real done.
    logic mon_prev = 1'b0;
    logic [8:0] mon_exp;
    always @(negedge iCLK) begin
        if (!iRST_N) begin
            mon_prev = 1'b0;
        end else begin
            if (oLCD_Start && !mon_prev) begin
                n_starts++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_start: got rs=%0d data=0x%0h expected none",
                             oLCD_RS, oLCD_DATA);
                end else begin
                    mon_exp = sb.pop_front();
                    check("lcd_rs_data", {23'd0, oLCD_RS, oLCD_DATA}, {23'd0, mon_exp});
                end
            end
            if (!oLCD_Start && mon_prev) begin
                n_falls++;
                check("start_held_until_done", {31'd0, real_done}, 32'd1);
            end
            mon_prev = oLCD_Start;
        end
    end

    task automatic push_frame();
        sb.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) sb.push_back({1'b1, exp_buf[i]});
`ifdef LCD_LINE2_EN
        sb.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) sb.push_back({1'b1, exp_buf[i]});
`endif
    endtask

    task automatic push_init();
        sb.push_back({1'b0, 8'h38});
        sb.push_back({1'b0, 8'h0C});
        sb.push_back({1'b0, 8'h01});
        sb.push_back({1'b0, 8'h06});
        push_frame();
    endtask

    task automatic refresh();
        @(negedge iCLK); iREFRESH = 1'b1;
        @(negedge iCLK); iREFRESH = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge iCLK); iWR = 1'b1; iWADDR = a; iWDATA = d;
        @(negedge iCLK); iWR = 1'b0;
        exp_buf[a] = d;
    endtask

    task automatic wait_falls(input int target);
        int k;
        k = 0;
        do begin
            @(negedge iCLK); #1;
            k++;
        end while (n_falls < target && k < 3000);
        if (n_falls < target) begin
            n_vec++; n_err++;
            $display("FAIL wait_falls_timeout: got %0d expected %0d", n_falls, target);
        end
    endtask

    task automatic wait_starts(input int target);
        int k;
        k = 0;
        do begin
            @(negedge iCLK); #1;
            k++;
        end while (n_starts < target && k < 3000);
        if (n_starts < target) begin
            n_vec++; n_err++;
            $display("FAIL wait_starts_timeout: got %0d expected %0d", n_starts, target);
        end
    endtask

    task automatic wait_idle();
        int k;
        int st;
        k = 0;
        do begin
            @(negedge iCLK); #1;
            k++;
        end while (!(oBusy == 1'b0 && sb.size() == 0) && k < 4000);
        if (k >= 4000) begin
            n_vec++; n_err++;
            $display("FAIL idle_timeout: got busy=%0d pending=%0d expected 0 0", oBusy, sb.size());
        end
        st = n_starts;
        repeat (60) @(negedge iCLK);
        check("stay_idle_busy", {31'd0, oBusy}, 32'd0);
        check("no_extra_start", n_starts, st);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", {31'd0, oBusy}, 32'd1);
        check("rst_init_done", {31'd0, oInitDone}, 32'd0);
        check("rst_start", {31'd0, oLCD_Start}, 32'd0);
        check("rst_rs", {31'd0, oLCD_RS}, 32'd0);
        check("rst_data", {24'd0, oLCD_DATA}, 32'd0);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
        repeat (3) @(negedge iCLK);
        check_reset_outputs();

        // Power-up and init; oInitDone rises as the fourth GAP ends.
        push_init();
        base = n_falls;
        iRST_N = 1'b1;
        wait_falls(base + 4);
        check("init_done_gap_start", {31'd0, oInitDone}, 32'd0);
        repeat (3) @(negedge iCLK);
        check("init_done_gap_end", {31'd0, oInitDone}, 32'd0);
        @(negedge iCLK);
        check("init_done_after_gap", {31'd0, oInitDone}, 32'd1);
        wait_idle();
        check("init_done_held", {31'd0, oInitDone}, 32'd1);

        // HELLO, refresh; three more requests mid-redraw merge into one redraw.
        wr(5'd0, 8'h48); wr(5'd1, 8'h45); wr(5'd2, 8'h4C); wr(5'd3, 8'h4C); wr(5'd4, 8'h4F);
        push_frame();
        base = n_falls;
        refresh();
        wait_falls(base + 3);
        push_frame();
        refresh();
        repeat (5) @(negedge iCLK);
        refresh();
        repeat (30) @(negedge iCLK);
        refresh();
        wait_idle();

        // Write to address 5 in the LOAD cycle of step 10: old byte goes out.
        wr(5'd5, 8'h5A);
        push_frame();
        base = n_falls;
        refresh();
        wait_falls(base + 6);
        repeat (4) @(negedge iCLK);
        iWR = 1'b1; iWADDR = 5'd5; iWDATA = 8'h41;
        @(negedge iCLK);
        iWR = 1'b0;
        wait_idle();
        exp_buf[5] = 8'h41;
        push_frame();
        refresh();
        wait_idle();

        // Reset during WAITDONE of step 10, then a full restart with a blank buffer.
        push_frame();
        base = n_starts;
        refresh();
        wait_starts(base + 7);
        repeat (3) @(negedge iCLK);
        check("start_before_reset", {31'd0, oLCD_Start}, 32'd1);
        #2 iRST_N = 1'b0;
        #1 check_reset_outputs();
        sb.delete();
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
        repeat (3) @(negedge iCLK);
        push_init();
        iRST_N = 1'b1;
        repeat (PWR - 2) @(negedge iCLK);
        check("restart_busy_pwrup", {31'd0, oBusy}, 32'd1);
        check("restart_no_start_yet", {31'd0, oLCD_Start}, 32'd0);
        wait_idle();
        check("restart_init_done", {31'd0, oInitDone}, 32'd1);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
